// File: rtl/frame_scheduler.sv
// frame_scheduler: streams one frame into the detection datapath, flushes it, then reads out per-label statistics.
// Define FRAME_SCHED_SKIP_EMPTY_EN to suppress results for zero-area objects.
module frame_scheduler #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int FLUSH_CYCLES = 2*FRAME_WIDTH+16,
    parameter int RD_LAT       = 2,
    parameter int LBL_WIDTH    = 8,
    parameter int LOC_SIZE     = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 en_o,
    output logic [LOC_SIZE-1:0]  x_o,
    output logic [LOC_SIZE-1:0]  y_o,
    input  logic [LBL_WIDTH-1:0] num_labels_i,
    input  logic [LOC_SIZE-1:0]  obj_area_i,
    input  logic [LOC_SIZE-1:0]  obj_x_i,
    input  logic [LOC_SIZE-1:0]  obj_y_i,
    output logic [LBL_WIDTH-1:0] obj_id_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [LBL_WIDTH-1:0] res_id_o,
    output logic [LOC_SIZE-1:0]  res_area_o,
    output logic [LOC_SIZE-1:0]  res_x_o,
    output logic [LOC_SIZE-1:0]  res_y_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, STREAM, FLUSH, SELECT, WAIT, EMIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [LOC_SIZE-1:0]  x_q, x_d, y_q, y_d;
    logic [LOC_SIZE-1:0]  area_q, area_d, rx_q, rx_d, ry_q, ry_d;
    logic [LBL_WIDTH-1:0] id_q, id_d, nlab_q, nlab_d, rid_q, rid_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;
    logic [2:0]           wcnt_q, wcnt_d;
    logic                 last_col, last_px, last_lbl, skip;

    assign last_col = x_q == LOC_SIZE'(FRAME_WIDTH-1);
    assign last_px  = last_col && y_q == LOC_SIZE'(FRAME_HEIGHT-1);
    assign last_lbl = id_q == nlab_q;
`ifdef FRAME_SCHED_SKIP_EMPTY_EN
    assign skip = obj_area_i == '0;
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        id_d    = id_q;
        nlab_d  = nlab_q;
        fcnt_d  = fcnt_q;
        wcnt_d  = wcnt_q;
        rid_d   = rid_q;
        area_d  = area_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = STREAM;
                x_d     = '0;
                y_d     = '0;
            end
            STREAM: if (in_valid_i) begin
                x_d = last_col ? '0 : x_q + LOC_SIZE'(1);
                y_d = last_px ? '0 : last_col ? y_q + LOC_SIZE'(1) : y_q;
                if (last_px) begin
                    state_d = FLUSH;
                    fcnt_d  = FW'(FLUSH_CYCLES-1);
                end
            end
            FLUSH: if (fcnt_q == '0) begin
                // Label count is frozen here so the readout loop bound cannot move under it.
                nlab_d  = num_labels_i;
                state_d = (num_labels_i != '0) ? SELECT : DONE;
                id_d    = (num_labels_i != '0) ? LBL_WIDTH'(1) : id_q;
            end else begin
                fcnt_d = fcnt_q - FW'(1);
            end
            SELECT: begin
                state_d = WAIT;
                wcnt_d  = 3'(RD_LAT-1);
            end
            WAIT: if (wcnt_q != '0) begin
                wcnt_d = wcnt_q - 3'd1;
            end else if (skip) begin
                state_d = last_lbl ? DONE : SELECT;
                id_d    = last_lbl ? id_q : id_q + LBL_WIDTH'(1);
            end else begin
                state_d = EMIT;
                rid_d   = id_q;
                area_d  = obj_area_i;
                rx_d    = obj_x_i;
                ry_d    = obj_y_i;
            end
            EMIT: if (res_ready_i) begin
                state_d = last_lbl ? DONE : SELECT;
                id_d    = last_lbl ? id_q : id_q + LBL_WIDTH'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            id_q    <= '0;
            nlab_q  <= '0;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
            rid_q   <= '0;
            area_q  <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            id_q    <= id_d;
            nlab_q  <= nlab_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            rid_q   <= rid_d;
            area_q  <= area_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
        end
    end

    assign in_ready_o   = state_q == STREAM;
    assign en_o         = (state_q == STREAM && in_valid_i) || state_q == FLUSH;
    assign x_o          = x_q;
    assign y_o          = y_q;
    assign obj_id_o     = id_q;
    assign res_valid_o  = state_q == EMIT;
    assign res_id_o     = rid_q;
    assign res_area_o   = area_q;
    assign res_x_o      = rx_q;
    assign res_y_o      = ry_q;
    assign busy_o       = state_q != IDLE;
    assign frame_done_o = state_q == DONE;
endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter FRAME_WIDTH, default 640: pixels per row.
REQ-002 Parameter FRAME_HEIGHT, default 480: rows per frame.
REQ-003 Parameter FLUSH_CYCLES, default 2*FRAME_WIDTH+16: en cycles issued after the last pixel so the detection pipeline drains.
REQ-004 Parameter RD_LAT, default 2, range 1..7: cycles from obj_id change to valid object statistics.
REQ-005 Parameters LBL_WIDTH (default 8) and LOC_SIZE (default 32): label and location/statistic widths.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle request to process one frame; honoured only in IDLE.
REQ-009 in_valid  in  1, in_ready  out  1: pixel-stream handshake; a pixel transfers when both are high.
REQ-010 en  out  1, x  out  LOC_SIZE, y  out  LOC_SIZE: datapath advance strobe and coordinate of the current pixel.
REQ-011 num_labels  in  LBL_WIDTH: label count reported by the datapath.
REQ-012 obj_area, obj_x, obj_y  in  LOC_SIZE each: statistics for the selected object.
REQ-013 obj_id  out  LBL_WIDTH: object selector driven to the datapath.
REQ-014 res_valid  out  1, res_ready  in  1: result handshake; a result transfers when both are high.
REQ-015 res_id  out  LBL_WIDTH, res_area, res_x, res_y  out  LOC_SIZE each: captured result, held stable while res_valid=1 and res_ready=0.
REQ-016 busy  out  1, frame_done  out  1: busy is high in every state except IDLE; frame_done is a one-cycle completion pulse.

Function
REQ-017 Operation SHALL follow an FSM with states IDLE, STREAM, FLUSH, SELECT, WAIT, EMIT and DONE.
REQ-018 IDLE->STREAM on start=1; x, y SHALL be cleared to 0 on entry.
REQ-019 In STREAM, in_ready=1 and en=in_valid; any other state SHALL drive in_ready=0.
REQ-020 On each transfer, x SHALL increment; at x=FRAME_WIDTH-1, x SHALL wrap to 0 and y SHALL increment.
REQ-021 A transfer at (FRAME_WIDTH-1, FRAME_HEIGHT-1) SHALL move STREAM->FLUSH, and the flush counter SHALL load FLUSH_CYCLES-1.
REQ-022 In FLUSH, en=1 every cycle and x=y=0.
REQ-023 When the flush counter reaches 0, FLUSH SHALL move to SELECT if num_labels>0, otherwise to DONE; FLUSH lasts exactly FLUSH_CYCLES cycles.
REQ-024 Entering SELECT from FLUSH SHALL set obj_id=1; label 0 is background and is never reported.
REQ-025 SELECT->WAIT in one cycle.
REQ-026 WAIT SHALL last RD_LAT cycles, then capture obj_id, obj_area, obj_x and obj_y into the res_* outputs and move to EMIT.
REQ-027 In EMIT, res_valid=1.
REQ-028 On a transfer in EMIT: if obj_id=num_labels, go to DONE; otherwise increment obj_id and go to SELECT.
REQ-029 The label compare SHALL be unsigned at LBL_WIDTH; num_labels SHALL be sampled once at FLUSH exit and held for the readout.
REQ-030 DONE SHALL assert frame_done for exactly one cycle, then return to IDLE.
REQ-031 en SHALL be 0 in IDLE, SELECT, WAIT, EMIT and DONE, so the datapath is frozen during readout.
REQ-032 start SHALL be ignored in every state except IDLE; start coincident with reset is also ignored.
REQ-033 The result throughput limit is one result per RD_LAT+2 cycles; backpressure on res_ready SHALL stall indefinitely without loss.

Reset
REQ-034 While reset=1 at a clock edge, the next state SHALL be IDLE, regardless of the current state, including mid-stream or mid-readout.
REQ-035 Reset values: x=y=0, obj_id=0, res_*=0, en=0, in_ready=0, res_valid=0, busy=0, frame_done=0, flush counter=0.

Configuration
REQ-036 Macro FRAME_SCHED_SKIP_EMPTY_EN SHALL control whether empty objects are reported.
REQ-037 With FRAME_SCHED_SKIP_EMPTY_EN defined, a captured object with obj_area=0 SHALL NOT enter EMIT; the FSM SHALL advance as if the object had transferred (next label or DONE), and res_valid SHALL stay 0.
REQ-038 Without FRAME_SCHED_SKIP_EMPTY_EN, every label 1..num_labels SHALL be emitted, including zero-area objects.

Verification
REQ-039 Reset/idle: FRAME_WIDTH=4, FRAME_HEIGHT=2, FLUSH_CYCLES=3; hold reset 2 cycles -> all outputs 0; pulse start -> busy=1 next cycle and x=y=0.
REQ-040 Stream with gaps: 8 pixels with in_valid toggling -> en pulses match transfers and (x,y) runs (0,0)..(3,0),(0,1)..(3,1); then en=1 for exactly 3 cycles with in_ready=0.
REQ-041 Readout: num_labels=3, RD_LAT=2, res_ready=1 -> three results with res_id 1,2,3, each res_valid one cycle and spaced 4 cycles apart; frame_done pulses once after id 3.
REQ-042 Backpressure: res_ready=0 for 10 cycles during id 2 -> res_* held constant and res_valid stays high; no id skipped or repeated once res_ready=1.
REQ-043 Boundaries: num_labels=0 -> FLUSH->DONE with no res_valid; start asserted during FLUSH has no effect; reset during EMIT -> IDLE the next cycle and res_valid=0.
REQ-044 SKIP_EMPTY: macro defined, ids 1..3 with obj_area=5,0,7 -> only ids 1 and 3 emitted; macro undefined -> ids 1, 2 and 3 all emitted.
